// File: rtl/vme_master_pkg.sv
// Shared types and constants for the VME memory-bus master.
package vme_master_pkg;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Default number of WAIT cycles tolerated before a transaction is declared dead.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Wait counter width; wide enough for the largest permitted TIMEOUT (65535).
  localparam int unsigned CNT_W = 16;

endpackage : vme_master_pkg

// File: rtl/vme_mem_master.sv
// VME memory master: accepts one user command at a time, issues a single-cycle
// read or write strobe on the VME memory bus, waits for the matching Done (or a
// timeout) and returns a response that is held until the user consumes it.
module vme_mem_master
  import vme_master_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              Clk,
  input  logic              rst_n,
  // user command channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // user response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // VME memory bus
  output logic [ADDR_W-1:0] VMEAddr,
  output logic [DATA_W-1:0] VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [DATA_W-1:0] VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_strb_q, rd_strb_d;
  logic                wr_strb_q, wr_strb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [CNT_W-1:0]    cnt_inc_s;
  logic                done_match_s;

  // Only the Done belonging to the operation in flight counts.
  assign done_match_s = write_q ? VMEWrDone : VMERdDone;
  assign cnt_inc_s    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-output decode for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_strb_d   = 1'b0;
    wr_strb_d   = 1'b0;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Capture the command; bus address/data then stay put until the
          // next acceptance, and the strobe is launched for the STROBE cycle.
          write_d   = req_write;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          rd_strb_d = ~req_write;
          wr_strb_d = req_write;
          state_d   = ST_STROBE;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_STROBE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        // A Done landing on the timeout cycle still completes normally.
        if (done_match_s) begin
          rdata_d     = write_q ? {DATA_W{1'b0}} : VMERdData;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          rdata_d     = {DATA_W{1'b0}};
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d     = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output storage; reset abandons any transaction.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rd_strb_q   <= 1'b0;
      wr_strb_q   <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_strb_q   <= rd_strb_d;
      wr_strb_q   <= wr_strb_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Ready is forced low while reset is asserted, high as soon as it releases.
  assign req_ready = rst_n & (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign VMEAddr   = addr_q;
  assign VMEWrData = wdata_q;
  assign VMERdMem  = rd_strb_q;
  assign VMEWrMem  = wr_strb_q;

endmodule : vme_mem_master

// File: tb/tb_vme_mem_master.sv
// Self-checking bench for vme_mem_master with a transaction-level reference model.
module tb_vme_mem_master;

  localparam int T = 8;

  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [15:0] VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem, VMEWrMem;
  logic [31:0] VMERdData = 32'h0;
  logic        VMERdDone = 1'b0, VMEWrDone = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  vme_mem_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(T)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  always #5 Clk = ~Clk;

  // Count strobe cycles seen on the bus.
  always @(posedge Clk) begin
    if (VMERdMem === 1'b1) rd_cnt <= rd_cnt + 1;
    if (VMEWrMem === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  typedef struct packed {
    logic [7:0]  n_rd;
    logic [7:0]  n_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wait_cyc;
    logic [31:0] rdata;
    logic        err;
    logic        stable;
    logic        busy_ok;
  } obs_t;

  function automatic string fmt(input obs_t o);
    return $sformatf("rd=%0d wr=%0d addr=%h wd=%h wait=%0d rdata=%h err=%b stable=%b hs=%b",
                     o.n_rd, o.n_wr, o.addr, o.wdata, o.wait_cyc, o.rdata, o.err, o.stable, o.busy_ok);
  endfunction

  // Reference model: lat is the WAIT cycle (1 = one cycle after the strobe) in
  // which a Done is driven, 0 = none; match says whether it is the right Done.
  function automatic obs_t model(input logic w, input logic [15:0] a, input logic [31:0] wd,
                                 input int lat, input logic match, input logic [31:0] rd);
    obs_t e;
    logic ok;
    ok         = match && (lat >= 1) && (lat <= T);
    e.n_rd     = w ? 8'd0 : 8'd1;
    e.n_wr     = w ? 8'd1 : 8'd0;
    e.addr     = a;
    e.wdata    = wd;
    e.wait_cyc = ok ? 8'(lat) : 8'(T);
    e.rdata    = (ok && !w) ? rd : 32'h0;
    e.err      = ~ok;
    e.stable   = 1'b1;
    e.busy_ok  = 1'b1;
    return e;
  endfunction

  // Drive one full transaction and record what the DUT did. Starts and ends
  // #1 after a rising edge with the DUT idle.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [31:0] wd,
                         input int lat, input logic match, input logic [31:0] rd,
                         input int hold, output obs_t o);
    int rd0, wr0;
    logic got;
    logic [31:0] r0;
    logic e0;
    o = '0;
    o.stable = 1'b1;
    o.busy_ok = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    if (req_ready !== 1'b1) o.busy_ok = 1'b0;
    @(posedge Clk); #1;
    req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = $urandom;
    o.addr = VMEAddr;
    o.wdata = VMEWrData;
    if (req_ready !== 1'b0) o.busy_ok = 1'b0;
    got = 1'b0;
    o.wait_cyc = 8'hFF;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(posedge Clk); #1;
      VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdData = $urandom;
      if (rsp_valid === 1'b1) begin
        o.wait_cyc = 8'(cyc - 1);
        got = 1'b1;
      end else begin
        if (req_ready !== 1'b0) o.busy_ok = 1'b0;
        if (cyc == lat) begin
          if (w == match) VMEWrDone = 1'b1;
          else begin
            VMERdDone = 1'b1;
            VMERdData = rd;
          end
        end
      end
    end
    VMERdDone = 1'b0; VMEWrDone = 1'b0;
    if (got) begin
      o.rdata = rsp_rdata;
      o.err = rsp_err;
      r0 = rsp_rdata;
      e0 = rsp_err;
      for (int h = 0; h < hold; h++) begin
        rsp_ready = 1'b0;
        @(posedge Clk); #1;
        if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 ||
            VMEAddr !== a || VMEWrData !== wd) o.stable = 1'b0;
        if (req_ready !== 1'b0) o.busy_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge Clk); #1;
      rsp_ready = 1'b0;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) o.busy_ok = 1'b0;
    end
    o.n_rd = 8'(rd_cnt - rd0);
    o.n_wr = 8'(wr_cnt - wr0);
  endtask

  task automatic test_reset();
    logic [85:0] outs;
    repeat (3) @(posedge Clk);
    #1;
    outs = {VMERdMem, VMEWrMem, VMEAddr, VMEWrData, rsp_valid, rsp_rdata, rsp_err, req_ready};
    n_cmp++;
    if (outs !== 86'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h required 0", outs);
    end
    @(negedge Clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_read();
    obs_t o, e;
    run_txn(1'b0, 16'h0004, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0, o);
    e = model(1'b0, 16'h0004, 32'h0, 1, 1'b1, 32'hDEADBEEF);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL read_lat1: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_write();
    obs_t o, e;
    run_txn(1'b1, 16'h0010, 32'h0000ABCD, 2, 1'b1, 32'h0, 0, o);
    e = model(1'b1, 16'h0010, 32'h0000ABCD, 2, 1'b1, 32'h0);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL write_lat2: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    int rd0;
    logic bad;
    run_txn(1'b0, 16'h0100, 32'h0, 0, 1'b1, 32'h0, 0, o);
    e = model(1'b0, 16'h0100, 32'h0, 0, 1'b1, 32'h0);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL timeout: got %s required %s", fmt(o), fmt(e));
    end
    // A stray read completion after the timeout must change nothing.
    rd0 = rd_cnt;
    bad = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    VMERdDone = 1'b1; VMERdData = 32'h12345678;
    @(posedge Clk); #1;
    VMERdDone = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad || rd_cnt != rd0) begin
      n_fail++;
      $display("FAIL late_done_ignored: got bad=%b strobes=%0d required bad=0 strobes=0", bad, rd_cnt - rd0);
    end
  endtask

  task automatic test_done_at_timeout();
    obs_t o, e;
    run_txn(1'b0, 16'h0200, 32'h0, T, 1'b1, 32'hCAFEF00D, 0, o);
    e = model(1'b0, 16'h0200, 32'h0, T, 1'b1, 32'hCAFEF00D);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL done_at_timeout: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_wrong_done();
    obs_t o, e;
    run_txn(1'b0, 16'h0300, 32'h0, 2, 1'b0, 32'h0, 0, o);
    e = model(1'b0, 16'h0300, 32'h0, 2, 1'b0, 32'h0);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL read_with_wrdone: got %s required %s", fmt(o), fmt(e));
    end
    run_txn(1'b1, 16'h0304, 32'h55AA55AA, 3, 1'b0, 32'h0, 0, o);
    e = model(1'b1, 16'h0304, 32'h55AA55AA, 3, 1'b0, 32'h0);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL write_with_rddone: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_reset_mid();
    logic [85:0] outs;
    logic bad;
    int rd0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0020; req_wdata = 32'h0;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    rst_n = 1'b0;
    #2;
    outs = {VMERdMem, VMEWrMem, VMEAddr, VMEWrData, rsp_valid, rsp_rdata, rsp_err, req_ready};
    n_cmp++;
    if (outs !== 86'h0) begin
      n_fail++;
      $display("FAIL reset_mid_values: got %h required 0", outs);
    end
    @(negedge Clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b required 1", req_ready);
    end
    @(posedge Clk); #1;
    rd0 = rd_cnt;
    VMERdDone = 1'b1; VMERdData = 32'hBADBAD00;
    @(posedge Clk); #1;
    VMERdDone = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) bad = 1'b1;
    end
    n_cmp++;
    if (bad || rd_cnt != rd0) begin
      n_fail++;
      $display("FAIL reset_mid_done_ignored: got bad=%b strobes=%0d required bad=0 strobes=0", bad, rd_cnt - rd0);
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    run_txn(1'b0, 16'h0400, 32'h0, 3, 1'b1, 32'h0BADCAFE, 5, o);
    e = model(1'b0, 16'h0400, 32'h0, 3, 1'b1, 32'h0BADCAFE);
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL rsp_backpressure: got %s required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic w, m;
    logic [15:0] a;
    logic [31:0] wd, rd;
    int lat, hold;
    for (int i = 0; i < 24; i++) begin
      w    = 1'($urandom);
      a    = 16'($urandom);
      wd   = $urandom;
      rd   = $urandom;
      lat  = $urandom_range(0, T + 2);
      m    = ($urandom_range(0, 4) != 0);
      hold = $urandom_range(0, 3);
      run_txn(w, a, wd, lat, m, rd, hold, o);
      e = model(w, a, wd, lat, m, rd);
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_%0d: got %s required %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_done_at_timeout();
    test_wrong_done();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_vme_mem_master

// File: doc/vme_mem_master.md
VME_MEM_MASTER -- requirements
Module: vme_mem_master

Interface
REQ-001 Parameter ADDR_W, default 16: width of VMEAddr and req_addr.
REQ-002 Parameter DATA_W, default 32: width of all data ports.
REQ-003 Parameter TIMEOUT, default 255, range 1..65535: maximum cycles to wait for Done after a strobe.
REQ-004 Clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  user command available.
REQ-007 req_ready  out  1  block accepts command this cycle.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  target address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  user consumes response.
REQ-013 rsp_rdata  out  DATA_W  read data; zero for writes and timeouts.
REQ-014 rsp_err  out  1  1 = transaction timed out.
REQ-015 VMEAddr  out  ADDR_W  bus address.
REQ-016 VMEWrData  out  DATA_W  bus write data.
REQ-017 VMERdMem  out  1  one-cycle read strobe.
REQ-018 VMEWrMem  out  1  one-cycle write strobe.
REQ-019 VMERdData  in  DATA_W  read data, valid when VMERdDone=1.
REQ-020 VMERdDone  in  1  one-cycle read completion.
REQ-021 VMEWrDone  in  1  one-cycle write completion.

Function
REQ-022 FSM states: IDLE, STROBE, WAIT, RESP.
REQ-023 req_ready SHALL equal 1 only in IDLE; a command is accepted when req_valid=1 and req_ready=1.
REQ-024 On acceptance, register req_write, req_addr and req_wdata, then go IDLE->STROBE.
REQ-025 In STROBE, drive exactly one of VMERdMem/VMEWrMem high for one cycle, according to the registered req_write, then go to WAIT.
REQ-026 VMEAddr and VMEWrData SHALL be registered and hold the accepted values from STROBE until the next acceptance.
REQ-027 In WAIT, only the Done matching the operation counts; a read completes on VMERdDone=1, a write on VMEWrDone=1.
REQ-028 On a read completion, capture VMERdData into rsp_rdata, set rsp_err=0, and go to RESP.
REQ-029 On a write completion, set rsp_rdata=0 and rsp_err=0, and go to RESP.
REQ-030 The wait counter SHALL be cleared in STROBE and incremented each WAIT cycle.
REQ-031 If the count reaches TIMEOUT without a matching Done, set rsp_err=1 and rsp_rdata=0, and go to RESP.
REQ-032 If a matching Done arrives in the same cycle the count reaches TIMEOUT, the Done SHALL win (rsp_err=0).
REQ-033 Minimum completion latency: a Done in the first WAIT cycle (1 cycle after the strobe) SHALL complete the transaction.
REQ-034 A Done in IDLE, STROBE or RESP, a non-matching Done, and a late Done after timeout SHALL all be ignored with no state change.
REQ-035 rsp_valid=1 exactly in RESP; leave RESP to IDLE when rsp_ready=1.
REQ-036 rsp_rdata and rsp_err SHALL be stable while rsp_valid=1.
REQ-037 Back-to-back throughput: one transaction per (3 + bus latency) cycles minimum; no outstanding transactions.

Reset
REQ-038 While rst_n=0, asynchronously: state=IDLE, VMERdMem=0, VMEWrMem=0, VMEAddr=0, VMEWrData=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-039 Reset mid-transaction SHALL abandon it with no response; a Done arriving after reset release SHALL be ignored.
REQ-040 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Structure
REQ-041 Package vme_master_pkg SHALL hold the FSM state enum and the default TIMEOUT constant.
REQ-042 Single module; no sub-module is warranted, and the timeout counter stays inline.

Verification
REQ-043 Read at addr 0x0004; responder returns VMERdDone plus 0xDEADBEEF 1 cycle after the strobe -> one-cycle VMERdMem with VMEAddr=0x0004; rsp_valid with rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-044 Write 0x0000ABCD to 0x0010; VMEWrDone 2 cycles after the strobe -> one-cycle VMEWrMem with VMEWrData=0x0000ABCD; response rdata=0, err=0.
REQ-045 TIMEOUT=8, no Done -> rsp_err=1 after 8 WAIT cycles; a VMERdDone 3 cycles later is ignored and the FSM stays in IDLE.
REQ-046 Done coincident with the count reaching TIMEOUT -> rsp_err=0 with the captured data.
REQ-047 rst_n pulsed low in WAIT, then a Done is driven -> no rsp_valid, all outputs at reset values, req_ready=1 after release.
REQ-048 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable throughout; req_ready=0 until the handshake completes.
